// File: rtl/mcyc_ctrl_if.sv
// mcyc_ctrl_if: decoder/datapath handshake bundle; slave is the controller side, master the driver side
interface mcyc_ctrl_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       LongIn;
  logic       MemReady;
  logic       IRWrite;
  logic       AdrSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       FPUW;
  logic       Branch;
  logic       ALUOp;
  logic       Long;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       MemReq;
  logic       FPUStart;
  logic       Busy;
  modport slave (
    input  Op, Funct, LongIn, MemReady,
    output IRWrite, AdrSrc, NextPC, RegW, MemW, FPUW, Branch, ALUOp, Long,
           ALUSrcA, ALUSrcB, ResultSrc, MemReq, FPUStart, Busy
  );
  modport master (
    output Op, Funct, LongIn, MemReady,
    input  IRWrite, AdrSrc, NextPC, RegW, MemW, FPUW, Branch, ALUOp, Long,
           ALUSrcA, ALUSrcB, ResultSrc, MemReq, FPUStart, Busy
  );
endinterface

// File: rtl/mcyc_ctrl.sv
// mcyc_ctrl: multicycle main controller (clk, async reset, bus: Op/Funct/LongIn/MemReady in, datapath controls out)
module mcyc_ctrl #(
  parameter int FPU_LAT  = 4,
  parameter bit WAIT_MEM = 1'b1,
  parameter int CNT_W    = $clog2(FPU_LAT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  mcyc_ctrl_if.slave  bus
);
  typedef enum logic [4:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
    EXECF, ALUWB, ALUWB2, FPUWB, BRANCH, UNKNOWN
  } state_t;
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic rdy, cnt_done;
  assign rdy      = WAIT_MEM ? bus.MemReady : 1'b1;
  assign cnt_done = cnt == CNT_W'(FPU_LAT - 1);
  // counter is held at zero outside EXECF so every entry starts from zero
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= (state != EXECF) ? '0 : ((&cnt) ? cnt : cnt + CNT_W'(1));
    end
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:  next = rdy ? DECODE : FETCH;
      DECODE: next = (bus.Op == 2'b00) ? (bus.Funct[5] ? EXECI : EXECR) :
                     (bus.Op == 2'b01) ? MEMADR :
                     (bus.Op == 2'b10) ? BRANCH : EXECF;
      EXECR,
      EXECI:  next = bus.LongIn ? ALUWB2 : ALUWB;
      MEMADR: next = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:  next = rdy ? MEMWB : MEMRD;
      MEMWR:  next = rdy ? FETCH : MEMWR;
      EXECF:  next = cnt_done ? FPUWB : EXECF;
      default: next = FETCH;
    endcase
  end
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.FPUW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.Long      = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.MemReq    = 1'b0;
    bus.FPUStart  = 1'b0;
    bus.Busy      = state != FETCH;
    case (state)
      FETCH: begin
        bus.MemReq    = 1'b1;
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = rdy;
        bus.NextPC    = rdy;
      end
      DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      EXECR: bus.ALUOp = 1'b1;
      EXECI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
      end
      MEMADR: bus.ALUSrcB = 2'b01;
      MEMRD: begin
        bus.AdrSrc = 1'b1;
        bus.MemReq = 1'b1;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemReq = 1'b1;
        bus.MemW   = 1'b1;
      end
      MEMWB: begin
        bus.RegW      = 1'b1;
        bus.ResultSrc = 2'b01;
      end
      ALUWB:  bus.RegW = 1'b1;
      ALUWB2: begin
        bus.RegW = 1'b1;
        bus.Long = 1'b1;
      end
      EXECF: bus.FPUStart = cnt == '0;
      FPUWB: bus.FPUW = 1'b1;
      BRANCH: begin
        bus.Branch    = 1'b1;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mcyc_ctrl.sv
// tb_mcyc_ctrl: directed self-checking bench for mcyc_ctrl (default config plus FPU_LAT=1, WAIT_MEM=0)
module tb_mcyc_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mcyc_ctrl_if bus ();
  mcyc_ctrl_if bus2 ();
  mcyc_ctrl #(.FPU_LAT(4), .WAIT_MEM(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  mcyc_ctrl #(.FPU_LAT(1), .WAIT_MEM(1'b0)) dut2 (.clk(clk), .reset(reset2), .bus(bus2));
  // {IRWrite,AdrSrc,NextPC,RegW,MemW,FPUW,Branch,ALUOp,Long,ALUSrcA,ALUSrcB,ResultSrc,MemReq,FPUStart,Busy}
  wire [17:0] ctl = {bus.IRWrite, bus.AdrSrc, bus.NextPC, bus.RegW, bus.MemW, bus.FPUW, bus.Branch,
                     bus.ALUOp, bus.Long, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.MemReq,
                     bus.FPUStart, bus.Busy};
  wire [17:0] ctl2 = {bus2.IRWrite, bus2.AdrSrc, bus2.NextPC, bus2.RegW, bus2.MemW, bus2.FPUW, bus2.Branch,
                      bus2.ALUOp, bus2.Long, bus2.ALUSrcA, bus2.ALUSrcB, bus2.ResultSrc, bus2.MemReq,
                      bus2.FPUStart, bus2.Busy};
  localparam logic [17:0] V_FR  = 18'b1_0_1_0_0_0_0_0_0_01_10_10_1_0_0;
  localparam logic [17:0] V_FW  = 18'b0_0_0_0_0_0_0_0_0_01_10_10_1_0_0;
  localparam logic [17:0] V_DEC = 18'b0_0_0_0_0_0_0_0_0_01_10_10_0_0_1;
  localparam logic [17:0] V_XR  = 18'b0_0_0_0_0_0_0_1_0_00_00_00_0_0_1;
  localparam logic [17:0] V_XI  = 18'b0_0_0_0_0_0_0_1_0_00_01_00_0_0_1;
  localparam logic [17:0] V_MA  = 18'b0_0_0_0_0_0_0_0_0_00_01_00_0_0_1;
  localparam logic [17:0] V_MR  = 18'b0_1_0_0_0_0_0_0_0_00_00_00_1_0_1;
  localparam logic [17:0] V_MW  = 18'b0_1_0_0_1_0_0_0_0_00_00_00_1_0_1;
  localparam logic [17:0] V_WB  = 18'b0_0_0_1_0_0_0_0_0_00_00_01_0_0_1;
  localparam logic [17:0] V_AW  = 18'b0_0_0_1_0_0_0_0_0_00_00_00_0_0_1;
  localparam logic [17:0] V_AW2 = 18'b0_0_0_1_0_0_0_0_1_00_00_00_0_0_1;
  localparam logic [17:0] V_F0  = 18'b0_0_0_0_0_0_0_0_0_00_00_00_0_1_1;
  localparam logic [17:0] V_FN  = 18'b0_0_0_0_0_0_0_0_0_00_00_00_0_0_1;
  localparam logic [17:0] V_FWB = 18'b0_0_0_0_0_1_0_0_0_00_00_00_0_0_1;
  localparam logic [17:0] V_BR  = 18'b0_0_0_0_0_0_1_0_0_00_01_10_0_0_1;
  task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic long_in);
    bus.Op = op;
    bus.Funct = funct;
    bus.LongIn = long_in;
  endtask
  task automatic test_reset;
    bus.MemReady = 1'b1;
    set_instr(2'b00, 6'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== V_FR) begin errors++; $display("FAIL reset_fetch_rdy: got %b want %b", ctl, V_FR); end
    bus.MemReady = 1'b0;
    #1;
    checks++;
    if (ctl !== V_FW) begin errors++; $display("FAIL reset_fetch_wait: got %b want %b", ctl, V_FW); end
    @(posedge clk);
    #1;
    checks++;
    if (ctl !== V_FW) begin errors++; $display("FAIL reset_hold: got %b want %b", ctl, V_FW); end
    reset = 1'b0;
  endtask
  task automatic test_reset_mid;
    logic [17:0] ev [5];
    logic [4:0] mv;
    set_instr(2'b01, 6'b000001, 1'b0);
    ev = '{V_FR, V_DEC, V_MA, V_MR, V_FN};
    mv = 5'b11100;
    for (int i = 0; i < 4; i++) begin
      bus.MemReady = mv[4-i];
      @(negedge clk);
      checks++;
      if (ctl !== ev[i]) begin errors++; $display("FAIL reset_mid_pre[%0d]: got %b want %b", i, ctl, ev[i]); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== V_FW) begin errors++; $display("FAIL reset_mid_async: got %b want %b", ctl, V_FW); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    ev = '{V_FR, V_DEC, V_MA, V_MR, V_WB};
    for (int i = 0; i < 5; i++) begin
      bus.MemReady = 1'b1;
      @(negedge clk);
      checks++;
      if (ctl !== ev[i]) begin errors++; $display("FAIL reset_mid_post[%0d]: got %b want %b", i, ctl, ev[i]); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_add;
    logic [17:0] ev [4];
    set_instr(2'b00, 6'b000000, 1'b0);
    ev = '{V_FR, V_DEC, V_XR, V_AW};
    for (int i = 0; i < 4; i++) begin
      bus.MemReady = 1'b1;
      @(negedge clk);
      checks++;
      if (ctl !== ev[i]) begin errors++; $display("FAIL add[%0d]: got %b want %b", i, ctl, ev[i]); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_ldr_wait;
    logic [17:0] ev [7];
    logic [6:0] mv;
    set_instr(2'b01, 6'b000001, 1'b0);
    ev = '{V_FR, V_DEC, V_MA, V_MR, V_MR, V_MR, V_WB};
    mv = 7'b1110011;
    for (int i = 0; i < 7; i++) begin
      bus.MemReady = mv[6-i];
      @(negedge clk);
      checks++;
      if (ctl !== ev[i]) begin errors++; $display("FAIL ldr_wait[%0d]: got %b want %b", i, ctl, ev[i]); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_str_wait;
    logic [17:0] ev [8];
    logic [7:0] mv;
    set_instr(2'b01, 6'b000000, 1'b0);
    ev = '{V_FW, V_FW, V_FW, V_FR, V_DEC, V_MA, V_MW, V_MW};
    mv = 8'b00011101;
    for (int i = 0; i < 8; i++) begin
      bus.MemReady = mv[7-i];
      @(negedge clk);
      checks++;
      if (ctl !== ev[i]) begin errors++; $display("FAIL str_wait[%0d]: got %b want %b", i, ctl, ev[i]); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_fpu;
    logic [17:0] ev [7];
    set_instr(2'b11, 6'b000000, 1'b0);
    ev = '{V_FR, V_DEC, V_F0, V_FN, V_FN, V_FN, V_FWB};
    for (int i = 0; i < 7; i++) begin
      bus.MemReady = 1'b1;
      @(negedge clk);
      checks++;
      if (ctl !== ev[i]) begin errors++; $display("FAIL fpu[%0d]: got %b want %b", i, ctl, ev[i]); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_long_branch;
    logic [17:0] ev [8];
    ev = '{V_FR, V_DEC, V_XI, V_AW2, V_FR, V_DEC, V_BR, V_FR};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) set_instr(2'b00, 6'b100000, 1'b1);
      else set_instr(2'b10, 6'b000000, 1'b0);
      bus.MemReady = 1'b1;
      @(negedge clk);
      checks++;
      if (ctl !== ev[i]) begin errors++; $display("FAIL long_branch[%0d]: got %b want %b", i, ctl, ev[i]); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_lat1_nowait;
    logic [17:0] ev [5];
    bus2.Op = 2'b11;
    bus2.Funct = 6'b0;
    bus2.LongIn = 1'b0;
    bus2.MemReady = 1'bx;
    reset2 = 1'b0;
    ev = '{V_FR, V_DEC, V_F0, V_FWB, V_FR};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ctl2 !== ev[i]) begin errors++; $display("FAIL lat1_nowait[%0d]: got %b want %b", i, ctl2, ev[i]); end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    bus2.Op = 2'b00;
    bus2.Funct = 6'b0;
    bus2.LongIn = 1'b0;
    bus2.MemReady = 1'bx;
    test_reset;
    test_reset_mid;
    test_add;
    test_ldr_wait;
    test_str_wait;
    test_fpu;
    test_long_branch;
    test_lat1_nowait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcyc_ctrl.md
# mcyc_ctrl

Parametrised multicycle main controller for the ARM-subset datapath, successor to the current main FSM. It sequences fetch, decode, ALU, memory, branch and FPU instructions, and emits the same datapath control vector. It adds a memory ready handshake with wait states and a configurable-latency FPU execute phase driven by an internal counter. It sits between the instruction register/decoder and the shared-memory multicycle datapath.

## Interface
Parameters:
- FPU_LAT, 4: cycles spent in FPU execute, legal range 1..255.
- WAIT_MEM, 1: 1 = honour MemReady; 0 = MemReady is treated as constant 1.
- CNT_W, $clog2(FPU_LAT+1): FPU counter width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- Op  in  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 FPU
- Funct  in  6  Funct[5] selects immediate; Funct[0] selects load
- LongIn  in  1  data-proc result needs second write-back (long multiply)
- MemReady  in  1  memory access completes this cycle
- IRWrite, AdrSrc, NextPC, RegW, MemW, FPUW, Branch, ALUOp, Long  out  1 each  datapath controls
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects
- MemReq  out  1  memory access in progress
- FPUStart  out  1  one-cycle FPU launch pulse
- Busy  out  1  high in every state except FETCH

## Operation
- States (5-bit encoding): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, EXECF, ALUWB, ALUWB2, FPUWB, BRANCH, UNKNOWN.
- Transitions:
  - FETCH->DECODE when rdy (rdy = MemReady, or 1 if WAIT_MEM=0); otherwise hold in FETCH.
  - DECODE by Op: 00->EXECI if Funct[5], else EXECR; 01->MEMADR; 10->BRANCH; 11->EXECF.
  - EXECR/EXECI->ALUWB2 if LongIn, else ALUWB.
  - MEMADR->MEMRD if Funct[0], else MEMWR.
  - MEMRD->MEMWB when rdy, else hold.
  - MEMWR->FETCH when rdy, else hold.
  - EXECF->FPUWB when the counter reaches FPU_LAT-1, else hold.
  - MEMWB, ALUWB, ALUWB2, FPUWB, BRANCH, UNKNOWN->FETCH.
- Outputs are 0 unless listed:
  - FETCH: MemReq=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=rdy.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - EXECR: ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1, MemReq=1.
  - MEMWR: AdrSrc=1, MemReq=1, MemW=1; MemW is held for every wait cycle.
  - MEMWB: RegW=1, ResultSrc=01.
  - ALUWB: RegW=1.
  - ALUWB2: RegW=1, Long=1.
  - EXECF: FPUStart=1 only in the first EXECF cycle (counter==0).
  - FPUWB: FPUW=1.
  - BRANCH: Branch=1, ALUSrcB=01, ResultSrc=10.
  - UNKNOWN: all 0.
- FPU counter:
  - Cleared on reset and on every entry to EXECF.
  - Increments each EXECF cycle.
  - Saturating; never wraps within a valid FPU_LAT.
- Outputs are combinational from state, plus rdy (FETCH only) and counter==0 (EXECF only).

## Timing
- Reset, asynchronous: state=FETCH, counter=0.
  - While reset is high, outputs show FETCH values: MemReq=1, IRWrite=NextPC=rdy.
  - Reset in the middle of any wait state returns to FETCH immediately, with no partial write-back.
- Zero-wait latency, in cycles (including FETCH):
  - Data-proc: 4; long multiply also 4 (ALUWB2 replaces ALUWB).
  - Load: 5. Store: 4. Branch: 3.
  - FPU: 3 + FPU_LAT.
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle. All other controls stay stable during the wait.
- FPUStart is exactly one cycle per FPU instruction. FPUW is asserted exactly FPU_LAT cycles after FPUStart.
- FPU_LAT=1: EXECF lasts one cycle, with FPUStart=1; then FPUWB.
- WAIT_MEM=0: MemReady is ignored entirely, including X values.

## Test plan
- Reset mid-MEMRD (MemReady=0) -> next sampled state is FETCH, RegW=0; after release, FETCH with MemReady=1 gives IRWrite=NextPC=1 for one cycle.
- ADD register form (Op=00, Funct=000000, LongIn=0), MemReady=1 -> FETCH, DECODE, EXECR (ALUOp=1), ALUWB (RegW=1), FETCH; 4 cycles.
- LDR (Op=01, Funct[0]=1), MemReady low for 2 cycles in MEMRD -> MEMRD lasts 3 cycles with AdrSrc=1, then MEMWB with ResultSrc=01, RegW=1.
- STR with MemReady low for 3 cycles in FETCH and 1 cycle in MEMWR -> IRWrite only in the ready cycle; MemW=1 for 2 consecutive cycles; returns to FETCH.
- FPU op (Op=11) with FPU_LAT=4 -> FPUStart in EXECF cycle 0 only; EXECF lasts 4 cycles; FPUW=1 in the following cycle.
- Long multiply (LongIn=1), then B (Op=10) -> ALUWB2 with RegW=Long=1; then BRANCH with Branch=1, ALUSrcB=01; Busy low only in FETCH.
